mystic_pc_unit: RTL and testbench

MYSTIC_PC_UNIT -- requirements
Module: mystic_pc_unit

---
 rtl/mystic_pc_unit.sv | 124 ++++++++++++
 tb/tb_mystic_pc_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mystic_pc_unit.sv
// Program-counter controller: fetch/execute handshake, redirect and misaligned-target trap.
// Optional compressed-instruction support is enabled with the MYSTIC_RVC_EN macro.
module mystic_pc_unit #(
  parameter int unsigned     XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  output logic            fetch_req_o,
  output logic [XLEN-1:0] fetch_addr_o,
  input  logic            fetch_ack_i,
  input  logic            is_compressed_i,
  input  logic            exec_ready_i,
  input  logic [1:0]      redirect_kind_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] target_i,
  input  logic            stall_i,
  input  logic [XLEN-1:0] trap_vector_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_next_o,
  output logic            trap_o,
  output logic [XLEN-1:0] trap_addr_o
);

  typedef enum logic [1:0] {S_INIT, S_FETCH, S_EXEC} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_next_q, pc_next_d;
  logic [XLEN-1:0] trap_addr_q, trap_addr_d;
  logic            fetch_req_q, fetch_req_d;
  logic            trap_q, trap_d;
  logic [XLEN-1:0] inc;
  logic [XLEN-1:0] cand;
  logic            misaligned;

`ifdef MYSTIC_RVC_EN
  assign inc        = is_compressed_i ? XLEN'(2) : XLEN'(4);
  assign misaligned = cand[0];
`else
  logic unused_is_compressed;
  assign unused_is_compressed = is_compressed_i;
  assign inc                  = XLEN'(4);
  assign misaligned           = |cand[1:0];
`endif

  always_comb begin
    unique case (redirect_kind_i)
      2'b01:   cand = branch_taken_i ? pc_q + target_i : pc_next_q;
      2'b10:   cand = pc_q + target_i;
      2'b11:   cand = target_i & ~XLEN'(1);
      default: cand = pc_next_q;
    endcase
  end

  // Stall holds every register, including the one-cycle trap pulse.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pc_next_d   = pc_next_q;
    fetch_req_d = fetch_req_q;
    trap_d      = trap_q;
    trap_addr_d = trap_addr_q;
    if (!stall_i) begin
      trap_d = 1'b0;
      unique case (state_q)
        S_INIT: begin
          state_d     = S_FETCH;
          fetch_req_d = 1'b1;
        end
        S_FETCH: begin
          if (fetch_ack_i) begin
            pc_next_d   = pc_q + inc;
            fetch_req_d = 1'b0;
            state_d     = S_EXEC;
          end
        end
        S_EXEC: begin
          if (exec_ready_i) begin
            state_d     = S_FETCH;
            fetch_req_d = 1'b1;
            if (misaligned) begin
              trap_d      = 1'b1;
              trap_addr_d = cand;
              pc_d        = trap_vector_i & ~XLEN'(3);
            end else begin
              pc_d = cand;
            end
          end
        end
        default: begin
          state_d     = S_INIT;
          fetch_req_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q     <= S_INIT;
      pc_q        <= RESET_VECTOR;
      pc_next_q   <= '0;
      fetch_req_q <= 1'b0;
      trap_q      <= 1'b0;
      trap_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pc_next_q   <= pc_next_d;
      fetch_req_q <= fetch_req_d;
      trap_q      <= trap_d;
      trap_addr_q <= trap_addr_d;
    end
  end

  assign fetch_req_o  = fetch_req_q;
  assign fetch_addr_o = pc_q;
  assign pc_o         = pc_q;
  assign pc_next_o    = pc_next_q;
  assign trap_o       = trap_q;
  assign trap_addr_o  = trap_addr_q;

endmodule

// File: tb/tb_mystic_pc_unit.sv
// Scoreboard bench for mystic_pc_unit (XLEN=64, RESET_VECTOR=0x1000).
// Expectations follow MYSTIC_RVC_EN when the same macro is defined for the bench.
module tb_mystic_pc_unit;

  localparam int unsigned XLEN = 64;
`ifdef MYSTIC_RVC_EN
  localparam bit Rvc = 1'b1;
`else
  localparam bit Rvc = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rstn;
  logic            fetch_req;
  logic [XLEN-1:0] fetch_addr;
  logic            fetch_ack;
  logic            is_compressed;
  logic            exec_ready;
  logic [1:0]      redirect_kind;
  logic            branch_taken;
  logic [XLEN-1:0] target;
  logic            stall;
  logic [XLEN-1:0] trap_vector;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next;
  logic            trap;
  logic [XLEN-1:0] trap_addr;

  mystic_pc_unit #(
    .XLEN         (XLEN),
    .RESET_VECTOR (64'h1000)
  ) dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .fetch_req_o     (fetch_req),
    .fetch_addr_o    (fetch_addr),
    .fetch_ack_i     (fetch_ack),
    .is_compressed_i (is_compressed),
    .exec_ready_i    (exec_ready),
    .redirect_kind_i (redirect_kind),
    .branch_taken_i  (branch_taken),
    .target_i        (target),
    .stall_i         (stall),
    .trap_vector_i   (trap_vector),
    .pc_o            (pc),
    .pc_next_o       (pc_next),
    .trap_o          (trap),
    .trap_addr_o     (trap_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic            trap;
    logic [XLEN-1:0] trap_addr;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic [XLEN-1:0] m_pc;
  logic [XLEN-1:0] m_pc_next;
  logic [XLEN-1:0] m_trap_addr;

  task automatic check_val(input string tag, input logic [XLEN-1:0] got,
                           input logic [XLEN-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_fetch();
    int budget = 10;
    while (fetch_req !== 1'b1 && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    check_val("fetch_req_wait", {63'd0, fetch_req}, 64'd1);
  endtask

  task automatic run_instr(input logic comp, input logic [1:0] kind, input logic taken,
                           input logic [XLEN-1:0] tgt, input logic [XLEN-1:0] tv,
                           input int stall_n);
    exp_t            e;
    logic [XLEN-1:0] cand;
    logic            mis;
    wait_fetch();
    check_val("fetch_addr", fetch_addr, m_pc);
    m_pc_next = m_pc + ((Rvc && comp) ? 64'd2 : 64'd4);
    case (kind)
      2'b01:   cand = taken ? m_pc + tgt : m_pc_next;
      2'b10:   cand = m_pc + tgt;
      2'b11:   cand = {tgt[XLEN-1:1], 1'b0};
      default: cand = m_pc_next;
    endcase
    mis         = Rvc ? cand[0] : (cand[1:0] != 2'b00);
    e.pc_next   = m_pc_next;
    e.trap      = mis;
    e.trap_addr = mis ? cand : m_trap_addr;
    e.pc        = mis ? {tv[XLEN-1:2], 2'b00} : cand;
    sb.push_back(e);

    fetch_ack     = 1'b1;
    is_compressed = comp;
    @(posedge clk);
    #1;
    fetch_ack = 1'b0;
    check_val("fetch_req_cleared", {63'd0, fetch_req}, 64'd0);
    check_val("pc_next_latched", pc_next, m_pc_next);
    check_val("trap_one_cycle", {63'd0, trap}, 64'd0);
    check_val("pc_during_exec", pc, m_pc);

    redirect_kind = kind;
    branch_taken  = taken;
    target        = tgt;
    trap_vector   = tv;
    exec_ready    = 1'b1;
    for (int i = 0; i < stall_n; i++) begin
      stall = 1'b1;
      @(posedge clk);
      #1;
      check_val("stall_pc_hold", pc, m_pc);
      check_val("stall_req_hold", {63'd0, fetch_req}, 64'd0);
      check_val("stall_trap_hold", {63'd0, trap}, 64'd0);
    end
    stall = 1'b0;
    @(posedge clk);
    #1;
    exec_ready    = 1'b0;
    redirect_kind = 2'b00;
    e = sb.pop_front();
    check_val("pc_redirect", pc, e.pc);
    check_val("trap", {63'd0, trap}, {63'd0, e.trap});
    check_val("trap_addr", trap_addr, e.trap_addr);
    check_val("pc_next_hold", pc_next, e.pc_next);
    check_val("fetch_req_set", {63'd0, fetch_req}, 64'd1);
    m_pc        = e.pc;
    m_trap_addr = e.trap_addr;
  endtask

  task automatic check_reset_values();
    check_val("rst_pc", pc, 64'h1000);
    check_val("rst_pc_next", pc_next, 64'd0);
    check_val("rst_fetch_req", {63'd0, fetch_req}, 64'd0);
    check_val("rst_trap", {63'd0, trap}, 64'd0);
    check_val("rst_trap_addr", trap_addr, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn          = 1'b0;
    fetch_ack     = 1'b0;
    is_compressed = 1'b0;
    exec_ready    = 1'b0;
    redirect_kind = 2'b00;
    branch_taken  = 1'b0;
    target        = '0;
    stall         = 1'b0;
    trap_vector   = '0;
    m_pc          = 64'h1000;
    m_pc_next     = '0;
    m_trap_addr   = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check_val("init_fetch_req", {63'd0, fetch_req}, 64'd1);
    check_val("init_fetch_addr", fetch_addr, 64'h1000);

    run_instr(1'b0, 2'b00, 1'b0, '0, '0, 0);                      // 0x1000 -> 0x1004
    run_instr(1'b1, 2'b00, 1'b0, '0, '0, 0);                      // -> 0x1006 (RVC) / 0x1008
    run_instr(1'b0, 2'b11, 1'b0, 64'h2000, '0, 0);
    run_instr(1'b0, 2'b01, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, '0, 0); // -> 0x1FF0
    run_instr(1'b0, 2'b11, 1'b0, 64'h2000, '0, 0);
    run_instr(1'b0, 2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFF0, '0, 0); // -> 0x2004
    run_instr(1'b0, 2'b11, 1'b0, 64'h3001, '0, 0);                // -> 0x3000
    run_instr(1'b0, 2'b11, 1'b0, 64'h100, '0, 0);
    run_instr(1'b0, 2'b10, 1'b0, 64'h6, 64'h8007, 0);             // trap when RVC off
    run_instr(1'b0, 2'b10, 1'b0, 64'h40, 64'h8007, 3);            // stalled redirect
    run_instr(1'b0, 2'b01, 1'b1, 64'h3, 64'h9000, 0);             // odd target traps
    run_instr(1'b0, 2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, '0, 0);
    run_instr(1'b0, 2'b00, 1'b0, '0, '0, 0);                      // wraps to 0

    // Reset in S_EXEC, overlapping a stalled redirect request.
    wait_fetch();
    fetch_ack = 1'b1;
    @(posedge clk);
    #1;
    fetch_ack     = 1'b0;
    exec_ready    = 1'b1;
    redirect_kind = 2'b11;
    target        = 64'h4000;
    stall         = 1'b1;
    rstn          = 1'b0;
    @(posedge clk);
    #1;
    check_reset_values();
    exec_ready = 1'b0;
    stall      = 1'b0;
    rstn       = 1'b1;
    @(posedge clk);
    #1;
    check_val("rerun_fetch_req", {63'd0, fetch_req}, 64'd1);
    check_val("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
